// File: rtl/main_memory.sv
// rtl/main_memory.sv - word-addressed memory responder below the cache, fixed read latency
//
// Purpose:
//   Holds 2**NA words of NBITS each. Every cycle the word at memAddress is
//   loaded into a READ_LAT-deep register pipeline, and memReadData is driven
//   from the last stage. A write commits once, on the rising edge of the
//   memMemWrite level. The cache has no request strobe and holds the level
//   for several cycles, so later cycles of the same assertion never rewrite
//   the word. A read of the address being committed in the same cycle
//   returns the new data (write-first).
//
// Ports:
//   clock         in   1      rising-edge clock
//   reset         in   1      synchronous, active-high; clears memory, pipeline, stats
//   memAddress    in   NA     word address from the cache
//   memWriteData  in   NBITS  write data from the cache
//   memMemWrite   in   1      write request level
//   memReadData   out  NBITS  read data, READ_LAT cycles after the address
//   wr_commit     out  1      one-cycle pulse in the cycle after a commit
//   wr_count      out  16     (MAIN_MEMORY_STATS_EN only) saturating commit count
//   rd_count      out  16     (MAIN_MEMORY_STATS_EN only) saturating address-change count
//
// Optional feature macro: MAIN_MEMORY_STATS_EN
//   When defined, adds the wr_count/rd_count statistics outputs.

module main_memory #(
    parameter int NBITS    = 8,
    parameter int NA       = 6,
    parameter int READ_LAT = 2     // legal 1..4; the cache needs <= 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NA-1:0]    memAddress,
    input  logic [NBITS-1:0] memWriteData,
    input  logic             memMemWrite,
    output logic [NBITS-1:0] memReadData,
`ifdef MAIN_MEMORY_STATS_EN
    output logic [15:0]      wr_count,
    output logic [15:0]      rd_count,
`endif
    output logic             wr_commit
);

    localparam int DEPTH = 1 << NA;

    logic [NBITS-1:0] mem   [DEPTH];
    logic [NBITS-1:0] stage [READ_LAT];
    logic             we_prev;
    logic             commit;

    // A commit happens only on the first cycle of a memMemWrite assertion.
    assign commit = memMemWrite & ~we_prev;

    // Storage array and write-edge tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            we_prev   <= 1'b0;
            wr_commit <= 1'b0;
        end else begin
            we_prev   <= memMemWrite;
            wr_commit <= commit;
            if (commit) begin
                mem[memAddress] <= memWriteData;
            end
        end
    end

    // Read pipeline. The address being read is always the address being
    // written, so a commit in this cycle forwards its data straight into
    // stage 0 instead of the stale array word.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < READ_LAT; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= commit ? memWriteData : mem[memAddress];
            for (int k = 1; k < READ_LAT; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign memReadData = stage[READ_LAT-1];

`ifdef MAIN_MEMORY_STATS_EN
    logic [NA-1:0] addr_prev;

    // rd_count approximates read requests: the cache has no strobe, so a new
    // address while not writing is taken as a new read.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_count  <= '0;
            rd_count  <= '0;
            addr_prev <= '0;
        end else begin
            addr_prev <= memAddress;
            if (commit && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
            if (!memMemWrite && memAddress != addr_prev && rd_count != 16'hFFFF) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule
